phase2speed_sequencer: RTL and testbench

PHASE2SPEED_SEQUENCER -- requirements
Module: phase2speed_sequencer

---
 rtl/phase2speed_sequencer_pkg.sv | 27 ++
 rtl/phase2speed_sequencer_if.sv | 32 +++
 rtl/phase_fifo.sv | 47 ++++
 rtl/phase2speed_sequencer.sv | 118 +++++++++++
 tb/tb_phase2speed_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/phase2speed_sequencer_pkg.sv
// Shared types and widths for the phase-to-speed sequencer slice.
package phase2speed_sequencer_pkg;

    localparam int PHASE_W    = 19;
    localparam int SPEED_W    = 16;
    localparam int SPEED_FRAC = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_TICK,
        S_ISSUE,
        S_WAIT_READY,
        S_CAPTURE
    } state_t;

    // The sample-rate divider free-runs everywhere except while stopped or re-initialising.
    function automatic logic div_active(input state_t s);
        return (s != S_IDLE) && (s != S_INIT);
    endfunction

    // States in which a tick cannot be honoured and counts as an overrun.
    function automatic logic conv_busy(input state_t s);
        return (s == S_ISSUE) || (s == S_WAIT_READY) || (s == S_CAPTURE);
    endfunction

endpackage

// File: rtl/phase2speed_sequencer_if.sv
// Upstream phase feed, datapath control/result and status bundle of the sequencer.
interface phase2speed_sequencer_if;
    import phase2speed_sequencer_pkg::*;

    logic               enable;
    logic [PHASE_W-1:0] phase_in;
    logic               phase_valid;
    logic               phase_accept;
    logic               p2s_reset;
    logic               p2s_sample;
    logic [PHASE_W-1:0] p2s_phase;
    logic [SPEED_W-1:0] p2s_speed;
    logic               p2s_ready;
    logic [SPEED_W-1:0] speed;
    logic               speed_valid;
    logic               underrun;
    logic               overrun;
    logic               timeout;

    modport slave (
        input  enable, phase_in, phase_valid, p2s_speed, p2s_ready,
        output phase_accept, p2s_reset, p2s_sample, p2s_phase,
               speed, speed_valid, underrun, overrun, timeout
    );

    modport master (
        output enable, phase_in, phase_valid, p2s_speed, p2s_ready,
        input  phase_accept, p2s_reset, p2s_sample, p2s_phase,
               speed, speed_valid, underrun, overrun, timeout
    );

endinterface

// File: rtl/phase_fifo.sv
// Synchronous FIFO for phase words; head is readable combinationally (zero-cycle read).
// Push ignored when full, pop ignored when empty; simultaneous push+pop keeps occupancy.
module phase_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/phase2speed_sequencer.sv
// Paces buffered phase words into the phase2speed datapath at RATE_DIV, speed_valid 2 clocks after p2s_ready.
// Upstream is throttled by phase_accept (FIFO not full); the datapath has no backpressure, only timeout.
module phase2speed_sequencer
    import phase2speed_sequencer_pkg::*;
#(
    parameter int RATE_DIV   = 100,
    parameter int TIMEOUT    = 64,
    parameter int WARMUP     = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    phase2speed_sequencer_if.slave bus
);
    localparam int DIV_W  = $clog2(RATE_DIV);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int WARM_W = $clog2(WARMUP + 2);

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WARM_W-1:0]  warm_cnt;
    logic [SPEED_W-1:0] speed_cap, speed_q;
    logic               speed_vld_q;
    logic [PHASE_W-1:0] phase_hold, fifo_head;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic               tick, wait_last;
    logic               init_c, sample_c, underrun_c, overrun_c, timeout_c;

    phase_fifo #(.WIDTH(PHASE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (bus.phase_in),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_push = bus.phase_valid && !fifo_full;
    assign tick      = div_active(state) && (div_cnt == DIV_W'(RATE_DIV - 1));
    assign wait_last = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (bus.enable) state_nxt = S_INIT;
            S_INIT:       state_nxt = S_WAIT_TICK;
            S_WAIT_TICK:  if (!bus.enable) state_nxt = S_IDLE;
                          else if (tick) state_nxt = S_ISSUE;
            S_ISSUE:      state_nxt = S_WAIT_READY;
            S_WAIT_READY: if (bus.p2s_ready) state_nxt = S_CAPTURE;
                          else if (wait_last) state_nxt = S_INIT;
            S_CAPTURE:    state_nxt = bus.enable ? S_WAIT_TICK : S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        init_c     = (state == S_INIT);
        sample_c   = (state == S_ISSUE);
        underrun_c = sample_c && fifo_empty;
        fifo_pop   = sample_c && !fifo_empty;
        overrun_c  = tick && conv_busy(state);
        timeout_c  = (state == S_WAIT_READY) && !bus.p2s_ready && wait_last;
    end

    // Divider phase is kept across conversions so ticks stay on a fixed grid.
    always_ff @(posedge clock) begin
        if (reset || !div_active(state)) div_cnt <= '0;
        else if (div_cnt == DIV_W'(RATE_DIV - 1)) div_cnt <= '0;
        else div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt    <= '0;
            warm_cnt    <= '0;
            speed_cap   <= '0;
            speed_q     <= '0;
            speed_vld_q <= 1'b0;
            phase_hold  <= '0;
        end else begin
            wait_cnt    <= (state == S_WAIT_READY) ? wait_cnt + 1'b1 : '0;
            speed_vld_q <= 1'b0;
            if (init_c)
                warm_cnt <= WARM_W'(WARMUP);
            else if (state == S_CAPTURE && warm_cnt != '0)
                warm_cnt <= warm_cnt - 1'b1;
            // The result is only guaranteed alongside the ready pulse.
            if (state == S_WAIT_READY && bus.p2s_ready)
                speed_cap <= bus.p2s_speed;
            if (state == S_CAPTURE && warm_cnt == '0) begin
                speed_q     <= speed_cap;
                speed_vld_q <= 1'b1;
            end
            if (fifo_pop)
                phase_hold <= fifo_head;
        end
    end

    assign bus.phase_accept = !fifo_full;
    assign bus.p2s_reset    = init_c;
    assign bus.p2s_sample   = sample_c;
    assign bus.p2s_phase    = fifo_pop ? fifo_head : phase_hold;
    assign bus.speed        = speed_q;
    assign bus.speed_valid  = speed_vld_q;
    assign bus.underrun     = underrun_c;
    assign bus.overrun      = overrun_c;
    assign bus.timeout      = timeout_c;

endmodule

// File: tb/tb_phase2speed_sequencer.sv
// Directed bench: sequencer with RATE_DIV=8, TIMEOUT=64, WARMUP=2, FIFO_DEPTH=4 against a latency model.
module tb_phase2speed_sequencer;
    import phase2speed_sequencer_pkg::*;

    logic clock;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   model_lat = 5;

    phase2speed_sequencer_if bus();

    phase2speed_sequencer #(
        .RATE_DIV   (8),
        .TIMEOUT    (64),
        .WARMUP     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath model: result = phase[15:0] + 0x10, ready model_lat clocks after the sample.
    initial begin
        logic [15:0] cap;
        bus.p2s_ready = 1'b0;
        bus.p2s_speed = '0;
        forever begin
            @(posedge clock); #1;
            if (bus.p2s_sample === 1'b1 && model_lat > 0) begin
                cap = bus.p2s_phase[15:0] + 16'h0010;
                repeat (model_lat) @(posedge clock);
                #1;
                bus.p2s_ready = 1'b1;
                bus.p2s_speed = cap;
                @(posedge clock); #1;
                bus.p2s_ready = 1'b0;
                bus.p2s_speed = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // which: 0 p2s_sample, 1 speed_valid, 2 overrun, 3 timeout. n = cycles stepped, budget+1 on expiry.
    task automatic wait_evt(input int which, input int budget, output int n);
        logic hit;
        n = 0;
        do begin
            step(1);
            n++;
            case (which)
                0:       hit = (bus.p2s_sample === 1'b1);
                1:       hit = (bus.speed_valid === 1'b1);
                2:       hit = (bus.overrun === 1'b1);
                default: hit = (bus.timeout === 1'b1);
            endcase
        end while (!hit && n <= budget);
    endtask

    initial begin
        logic [PHASE_W-1:0] w [5];
        int n;
        int cnt_s;
        int cnt_v;
        w[0] = 19'h00100;
        w[1] = 19'h00200;
        w[2] = 19'h00300;
        w[3] = 19'h00400;
        w[4] = 19'h00123;

        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.phase_in    = '0;
        bus.phase_valid = 1'b0;
        step(3);
        reset = 1'b0;
        check("rst_accept",   bus.phase_accept, 1);
        check("rst_speed",    bus.speed, 0);
        check("rst_speed_vld", bus.speed_valid, 0);
        check("rst_phase",    bus.p2s_phase, 0);
        check("rst_sample",   bus.p2s_sample, 0);
        check("rst_p2s_reset", bus.p2s_reset, 0);
        check("rst_flags",    {bus.underrun, bus.overrun, bus.timeout}, 0);

        // Fill the buffer while stopped; the fifth word must be held off.
        for (int i = 0; i < 4; i++) begin
            bus.phase_in    = w[i];
            bus.phase_valid = 1'b1;
            step(1);
            check("fill_accept", bus.phase_accept, (i < 3) ? 1 : 0);
        end
        bus.phase_in = w[4];
        step(2);
        check("full_hold_accept", bus.phase_accept, 0);

        // Cycle 0: start. INIT next, first sample 10 cycles later.
        bus.enable = 1'b1;
        step(1);
        check("init_pulse", bus.p2s_reset, 1);
        step(1);
        check("init_one_cycle", bus.p2s_reset, 0);
        step(7);
        check("no_sample_before_tick", bus.p2s_sample, 0);
        step(1);
        check("first_sample", bus.p2s_sample, 1);
        check("first_phase", bus.p2s_phase, w[0]);
        check("first_no_underrun", bus.underrun, 0);
        step(1);
        check("accept_after_pop", bus.phase_accept, 1);
        step(1);
        bus.phase_valid = 1'b0;
        check("fifth_pushed_full", bus.phase_accept, 0);

        // Warm-up drops the results of w0 and w1; w2 is the first reported.
        wait_evt(1, 40, n);
        check("warmup_first_valid_delay", n, 21);
        check("speed_w2", bus.speed, 16'h0310);
        step(1);
        check("speed_valid_one_cycle", bus.speed_valid, 0);
        wait_evt(1, 16, n);
        check("speed_valid_period", n, 7);
        check("speed_w3", bus.speed, 16'h0410);
        wait_evt(1, 16, n);
        check("speed_valid_period2", n, 8);
        check("speed_w4", bus.speed, 16'h0133);

        // Buffer now empty: the next issue repeats the last phase word.
        wait_evt(0, 16, n);
        check("underrun_sample_delay", n, 1);
        check("underrun_pulse", bus.underrun, 1);
        check("underrun_phase_repeat", bus.p2s_phase, 19'h00123);
        step(1);
        check("underrun_one_cycle", bus.underrun, 0);
        wait_evt(1, 16, n);
        check("underrun_result_delay", n, 6);
        check("underrun_speed", bus.speed, 16'h0133);

        // Slow datapath: one tick lands in WAIT_READY and is dropped.
        model_lat = 10;
        wait_evt(2, 16, n);
        check("overrun_delay", n, 8);
        check("overrun_no_sample", bus.p2s_sample, 0);
        step(1);
        check("overrun_one_cycle", bus.overrun, 0);
        wait_evt(1, 16, n);
        check("slow_result_delay", n, 4);
        wait_evt(0, 16, n);
        check("second_tick_issues", n, 4);
        wait_evt(2, 16, n);
        check("overrun_again", n, 7);

        // Stop while a conversion is outstanding: it completes, then nothing more.
        bus.enable = 1'b0;
        wait_evt(1, 16, n);
        check("stop_completes", n, 5);
        check("stop_speed", bus.speed, 16'h0133);
        cnt_s = 0;
        cnt_v = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (bus.p2s_sample === 1'b1)  cnt_s++;
            if (bus.speed_valid === 1'b1) cnt_v++;
        end
        check("idle_no_sample", cnt_s, 0);
        check("idle_no_valid", cnt_v, 0);

        // Timeout recovery after warm-up has already expired.
        bus.phase_in    = 19'h40000;
        bus.phase_valid = 1'b1;
        step(1);
        bus.phase_valid = 1'b0;
        model_lat  = 5;
        bus.enable = 1'b1;
        wait_evt(0, 20, n);
        check("restart_sample_delay", n, 10);
        check("restart_phase", bus.p2s_phase, 19'h40000);
        wait_evt(1, 40, n);
        check("restart_warmup_delay", n, 23);
        check("restart_speed", bus.speed, 16'h0010);
        model_lat = 0;
        wait_evt(0, 8, n);
        check("to_sample_delay", n, 1);
        wait_evt(3, 80, n);
        check("timeout_delay", n, 64);
        check("timeout_no_init_yet", bus.p2s_reset, 0);
        model_lat = 5;
        step(1);
        check("timeout_then_init", bus.p2s_reset, 1);
        check("timeout_one_cycle", bus.timeout, 0);
        wait_evt(1, 50, n);
        check("warmup_reloaded_delay", n, 32);
        check("recover_speed", bus.speed, 16'h0010);

        // Reset during WAIT_READY discards the conversion.
        wait_evt(0, 8, n);
        check("pre_reset_sample", n, 1);
        step(2);
        reset      = 1'b1;
        bus.enable = 1'b0;
        step(2);
        reset = 1'b0;
        check("midrst_speed", bus.speed, 0);
        check("midrst_phase", bus.p2s_phase, 0);
        check("midrst_accept", bus.phase_accept, 1);
        cnt_s = 0;
        cnt_v = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.p2s_sample === 1'b1)  cnt_s++;
            if (bus.speed_valid === 1'b1) cnt_v++;
        end
        check("midrst_no_valid", cnt_v, 0);
        check("midrst_no_sample", cnt_s, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
